// File: rtl/fec_sim_pkg.sv
// Shared constants and types for the PAM4 / interleaved RS(544,514) FEC
// Monte-Carlo engine: code geometry, Markov table depth, generator seeds
// and the xorshift step used by every lane's random source.
package fec_sim_pkg;
    localparam int N_PAR    = 5;    // PAM4 symbols per clock (= one 10-bit FEC symbol)
    localparam int CW_SYMS  = 544;  // FEC symbols per codeword
    localparam int T_CORR   = 15;   // correctable FEC symbols per codeword
    localparam int N_STATES = 84;   // burst-state table depth
    localparam int MAX_IL   = 15;   // interleaver codeword slots

    typedef logic [31:0] prob_t;

    // One distinct nonzero seed per lane; SEEDS[k] belongs to lane k.
    localparam logic [N_PAR-1:0][31:0] SEEDS = {
        32'h1F123BB5, 32'hC0FFEE11, 32'h9E3779B9, 32'h2545F491, 32'hDEADBEEF
    };

    function automatic prob_t xorshift32(prob_t x);
        prob_t y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction
endpackage

// File: rtl/parallel_sys_2_burst_channel.sv
// burst_channel: runtime-loaded probability table, per-lane xorshift
// generators and the burst Markov chain evaluated across all lanes.
//   clk, rstn    : clock, async active-low reset (table is not reset)
//   i_en         : advance generators and burst state
//   i_prob_data  : table write data
//   i_prob_idx   : table write address, >= N_STATES means no write
//   o_err        : raw channel symbol errors, lane 0 first in the chain
module burst_channel
    import fec_sim_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  prob_t            i_prob_data,
    input  logic [31:0]      i_prob_idx,
    output logic [N_PAR-1:0] o_err
);
    prob_t      r_table [N_STATES];
    prob_t      r_rng   [N_PAR];
    logic [6:0] r_state;

    prob_t      w_rand  [N_PAR];
    logic [6:0] w_s     [N_PAR+1];

    // Table writes ignore en and reset so a host can preload during reset.
    always_ff @(posedge clk) begin
        if (i_prob_idx < 32'(N_STATES))
            r_table[i_prob_idx[6:0]] <= i_prob_data;
    end

    // Each lane compares the generator's next output against the table entry
    // for the burst state left by the previous lane.
    always_comb begin
        w_s[0] = r_state;
        o_err  = '0;
        for (int k = 0; k < N_PAR; k++) begin
            w_rand[k] = xorshift32(r_rng[k]);
            o_err[k]  = (w_rand[k] < r_table[w_s[k]]);
            if (o_err[k])
                w_s[k+1] = (w_s[k] == 7'(N_STATES-1)) ? w_s[k] : w_s[k] + 7'd1;
            else
                w_s[k+1] = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= 7'd0;
            for (int k = 0; k < N_PAR; k++) r_rng[k] <= SEEDS[k];
        end else if (i_en) begin
            r_state <= w_s[N_PAR];
            for (int k = 0; k < N_PAR; k++) r_rng[k] <= w_rand[k];
        end
    end
endmodule

// File: rtl/parallel_sys_2.sv
// parallel_sys_2: FEC characterisation engine. Takes raw channel errors from
// burst_channel, applies optional 1+D precoding, distributes FEC symbols over
// up to 15 interleaved codewords and accumulates 64-bit statistics.
//   clk, rstn             : clock, async active-low reset
//   en                    : run enable; config latches only while low
//   probability_in/_idx   : probability table write port
//   precode_en            : 1+D precoding error model
//   n_interleave          : codewords per block (0 treated as 1)
//   total_*               : bit, pre/post-FEC error and frame counters
module parallel_sys_2
    import fec_sim_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [63:0] probability_in,
    input  logic [31:0] probability_idx,
    input  logic        precode_en,
    input  logic [3:0]  n_interleave,
    output logic [63:0] total_bits,
    output logic [63:0] total_bit_errors_pre,
    output logic [63:0] total_bit_errors_post,
    output logic [63:0] total_frames,
    output logic [63:0] total_frame_errors
);
    logic [N_PAR-1:0]             w_err, w_d;
    logic [2:0]                   w_nbits;
    logic                         w_sym_err, w_last;
    logic [13:0]                  w_blk_len;
    logic [MAX_IL-1:0][9:0]       w_cs_nxt;
    logic [MAX_IL-1:0][12:0]      w_cb_nxt;
    logic [4:0]                   w_fe_cnt;
    logic [16:0]                  w_post_add;
    logic                         w_unused_hi;

    logic [63:0]                  r_bits, r_pre, r_post, r_frames, r_ferr;
    logic                         r_last, r_precode;
    logic [3:0]                   r_n, r_slot;
    logic [13:0]                  r_sym_cnt;
    logic [MAX_IL-1:0][9:0]       r_cs;   // symbol errors per codeword slot
    logic [MAX_IL-1:0][12:0]      r_cb;   // bit errors per codeword slot

    assign w_unused_hi = ^probability_in[63:32];

    burst_channel u_chan (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (en),
        .i_prob_data (probability_in[31:0]),
        .i_prob_idx  (probability_idx),
        .o_err       (w_err)
    );

    // 1+D: an error shows up as a transition change, so lane k sees
    // err_k ^ err_{k-1}, with lane 0 pairing with last cycle's lane 4.
    assign w_d       = r_precode ? (w_err ^ {w_err[N_PAR-2:0], r_last}) : w_err;
    assign w_sym_err = |w_d;
    assign w_blk_len = 14'(CW_SYMS * int'(r_n));
    assign w_last    = (r_sym_cnt == w_blk_len - 14'd1);

    always_comb begin
        w_nbits    = '0;
        w_fe_cnt   = '0;
        w_post_add = '0;
        for (int k = 0; k < N_PAR; k++) w_nbits = w_nbits + 3'(w_d[k]);
        // Slot values including this cycle's symbol, so the block-end tally
        // sees the final symbol.
        for (int i = 0; i < MAX_IL; i++) begin
            w_cs_nxt[i] = r_cs[i] + (((4'(i) == r_slot) && w_sym_err) ? 10'd1 : 10'd0);
            w_cb_nxt[i] = r_cb[i] + ((4'(i) == r_slot) ? 13'(w_nbits) : 13'd0);
            if ((4'(i) < r_n) && (w_cs_nxt[i] > 10'(T_CORR))) begin
                w_fe_cnt   = w_fe_cnt + 5'd1;
                w_post_add = w_post_add + 17'(w_cb_nxt[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bits    <= '0;
            r_pre     <= '0;
            r_post    <= '0;
            r_frames  <= '0;
            r_ferr    <= '0;
            r_last    <= 1'b0;
            r_precode <= 1'b0;
            r_n       <= 4'd1;
            r_slot    <= '0;
            r_sym_cnt <= '0;
            r_cs      <= '0;
            r_cb      <= '0;
        end else if (!en) begin
            r_n       <= (n_interleave == 4'd0) ? 4'd1 : n_interleave;
            r_precode <= precode_en;
        end else begin
            r_bits <= r_bits + 64'd10;
            r_pre  <= r_pre + 64'(w_nbits);
            r_last <= w_err[N_PAR-1];
            if (w_last) begin
                r_frames  <= r_frames + 64'(r_n);
                r_ferr    <= r_ferr + 64'(w_fe_cnt);
                r_post    <= r_post + 64'(w_post_add);
                r_cs      <= '0;
                r_cb      <= '0;
                r_slot    <= '0;
                r_sym_cnt <= '0;
            end else begin
                r_cs      <= w_cs_nxt;
                r_cb      <= w_cb_nxt;
                r_slot    <= (r_slot == r_n - 4'd1) ? 4'd0 : r_slot + 4'd1;
                r_sym_cnt <= r_sym_cnt + 14'd1;
            end
        end
    end

    assign total_bits            = r_bits;
    assign total_bit_errors_pre  = r_pre;
    assign total_bit_errors_post = r_post;
    assign total_frames          = r_frames;
    assign total_frame_errors    = r_ferr;
endmodule

// File: tb/tb_parallel_sys_2.sv
// Directed + randomized bench for parallel_sys_2 against a reference model
// that follows the link rules with plain arithmetic on arrays.
module tb_parallel_sys_2;
    import fec_sim_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        en_i;
    logic [63:0] prob_i;
    logic [31:0] idx_i;
    logic        pc_i;
    logic [3:0]  nil_i;
    logic [63:0] o_bits, o_pre, o_post, o_fr, o_fe;

    int n_cmp = 0;
    int n_err = 0;

    parallel_sys_2 dut (
        .clk                   (clk),
        .rstn                  (rstn_i),
        .en                    (en_i),
        .probability_in        (prob_i),
        .probability_idx       (idx_i),
        .precode_en            (pc_i),
        .n_interleave          (nil_i),
        .total_bits            (o_bits),
        .total_bit_errors_pre  (o_pre),
        .total_bit_errors_post (o_post),
        .total_frames          (o_fr),
        .total_frame_errors    (o_fe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned     tbl_m [84];
    int unsigned     rng_m [5];
    int              st_m, last_m, p_m, n_m, j_m;
    int              cs_m [15];
    int              cb_m [15];
    longint unsigned m_bits, m_pre, m_post, m_fr, m_fe;

    function automatic int unsigned xs(input int unsigned x);
        int unsigned y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) rng_m[k] = SEEDS[k];
        st_m = 0; last_m = 0; p_m = 0; n_m = 1; j_m = 0;
        for (int i = 0; i < 15; i++) begin cs_m[i] = 0; cb_m[i] = 0; end
        m_bits = 0; m_pre = 0; m_post = 0; m_fr = 0; m_fe = 0;
    endtask

    task automatic model_step();
        int e, prev, nd;
        prev = last_m; nd = 0;
        for (int k = 0; k < 5; k++) begin
            rng_m[k] = xs(rng_m[k]);
            e = (rng_m[k] < tbl_m[st_m]) ? 1 : 0;
            st_m = e ? ((st_m < 83) ? st_m + 1 : 83) : 0;
            nd += p_m ? (e ^ prev) : e;
            prev = e;
        end
        last_m = prev;
        m_bits += 10;
        m_pre  += longint'(nd);
        cs_m[j_m % n_m] += (nd != 0) ? 1 : 0;
        cb_m[j_m % n_m] += nd;
        j_m++;
        if (j_m == 544 * n_m) begin
            m_fr += longint'(n_m);
            for (int i = 0; i < n_m; i++)
                if (cs_m[i] > 15) begin m_fe++; m_post += longint'(cb_m[i]); end
            for (int i = 0; i < 15; i++) begin cs_m[i] = 0; cb_m[i] = 0; end
            j_m = 0;
        end
    endtask

    // One clock: model mirrors what the edge does, then sample at negedge.
    task automatic tick();
        @(posedge clk);
        if (!rstn_i) model_reset();
        else if (!en_i) begin
            n_m = (nil_i == 0) ? 1 : int'(nil_i);
            p_m = int'(pc_i);
        end else model_step();
        if (idx_i < 84) tbl_m[idx_i] = prob_i[31:0];
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bits"}, o_bits, m_bits);
        chk({tag, ".pre"},  o_pre,  m_pre);
        chk({tag, ".post"}, o_post, m_post);
        chk({tag, ".frames"}, o_fr, m_fr);
        chk({tag, ".ferr"}, o_fe,   m_fe);
    endtask

    function automatic logic [31:0] tval(input int mode, input int s);
        if (mode == 0) return 32'h0;
        if (mode == 1) return 32'hFFFFFFFF;
        return (s == 0) ? $urandom_range(32'h00C00000, 0)
                        : $urandom_range(32'hF0000000, 32'h40000000);
    endfunction

    // Hold reset, load the whole table, then two writes that must be ignored.
    task automatic load_in_reset(input int mode);
        rstn_i = 1'b0; en_i = 1'b0;
        for (int s = 0; s < 84; s++) begin
            idx_i = s; prob_i = {32'hA5A5A5A5, tval(mode, s)}; tick();
        end
        idx_i = 32'hFFFFFFFF; prob_i = 64'h12345678_9ABCDEF0; tick();
        idx_i = 32'd84;       prob_i = 64'h0F0F0F0F_55AA55AA; tick();
        idx_i = 32'hFFFFFFFF;
        rstn_i = 1'b1; tick();   // en=0 edge latches config
    endtask

    task automatic run(input int cyc);
        en_i = 1'b1;
        repeat (cyc) tick();
        en_i = 1'b0;
    endtask

    initial begin
        rstn_i = 1'b0; en_i = 1'b0; prob_i = '0; idx_i = 32'hFFFFFFFF;
        pc_i = 1'b0; nil_i = 4'd1;
        model_reset();
        for (int s = 0; s < 84; s++) tbl_m[s] = 32'h0;
        #1;
        check_all("reset");

        // zero table: no errors, one frame
        load_in_reset(0);
        run(544);
        check_all("zero");
        chk("zero.bits_abs", o_bits, 64'd5440);
        chk("zero.frames_abs", o_fr, 64'd1);
        chk("zero.pre_abs", o_pre, 64'd0);

        // all-ones table, precode off: every symbol in error, frame fails
        load_in_reset(1);
        run(544);
        check_all("ones");
        chk("ones.ferr_abs", o_fe, 64'd1);
        chk("ones.pre_bound", 64'(o_pre >= 64'd2715), 64'd1);

        // same table retained through reset, precode on
        rstn_i = 1'b0; tick(); pc_i = 1'b1; rstn_i = 1'b1; tick();
        run(544);
        check_all("ones_pc");
        chk("ones_pc.ferr_abs", o_fe, 64'd0);
        chk("ones_pc.post_abs", o_post, 64'd0);

        // interleave 4: no frames until the 2176th symbol
        pc_i = 1'b0; nil_i = 4'd4;
        load_in_reset(0);
        run(2175);
        chk("il4.frames_before", o_fr, 64'd0);
        run(1);
        chk("il4.frames_after", o_fr, 64'd4);
        check_all("il4");

        // n_interleave = 0 behaves as 1
        rstn_i = 1'b0; tick(); nil_i = 4'd0; rstn_i = 1'b1; tick();
        run(544);
        chk("il0.frames", o_fr, 64'd1);

        // bursty random channel with random enables and live table writes
        nil_i = 4'($urandom_range(3, 1)); pc_i = 1'($urandom_range(1, 0));
        load_in_reset(2);
        for (int c = 0; c < 2000; c++) begin
            en_i = ($urandom_range(9, 0) < 8);
            if ($urandom_range(49, 0) == 0) begin
                idx_i = $urandom_range(83, 1); prob_i = {32'h0, tval(2, 1)};
            end else idx_i = 32'hFFFFFFFF;
            tick();
        end
        en_i = 1'b0; idx_i = 32'hFFFFFFFF; tick();
        check_all("rnd_pre_pause");
        repeat (100) tick();
        check_all("rnd_pause_hold");
        run(2500);
        check_all("rnd_resume");

        // async reset mid-block clears outputs without waiting for an edge
        run(37);
        #2 rstn_i = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick(); rstn_i = 1'b1; tick();
        run(600);
        check_all("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
